// File: rtl/ser_pkg.sv
// Shared definitions for the serial command decoder: opcodes, FSM encoding
// and the framebuffer address width.
package ser_pkg;

  localparam int ADDR_W = 16;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_FILL  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_COUNT   = 3'd3,
    ST_DATA    = 3'd4,
    ST_WRITE   = 3'd5
  } state_t;

endpackage

// File: rtl/ser_byte_fifo.sv
// Byte FIFO with a registered head-of-queue output; a byte pushed at one edge
// is visible on dout (and poppable) from the next edge onward.
module ser_byte_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_next;
  logic [DEPTH_LOG2:0]   count_reg;
  logic [7:0]            dout_reg;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_CNT);
  assign pop_ok  = pop && !empty;
  // At full a push is only accepted when a pop frees a slot on the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;

  assign rd_ptr_next = pop_ok ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
  assign dout        = dout_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg <= rd_ptr_next;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // New head is being written this edge when the queue drains to it.
      if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
        dout_reg <= din;
      end else begin
        dout_reg <= mem[rd_ptr_next];
      end
    end
  end

endmodule

// File: rtl/ser_cmd_decoder.sv
// Parses the serial byte stream into framebuffer single writes and
// address-incrementing fill bursts on a valid/ready write port.
module ser_cmd_decoder
  import ser_pkg::*;
#(
  parameter int         FIFO_DEPTH_LOG2 = 3,
  parameter logic [7:0] OP_WRITE        = ser_pkg::OP_WRITE,
  parameter logic [7:0] OP_FILL         = ser_pkg::OP_FILL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_full,
  input  logic [7:0]        rx_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              overrun,
  output logic [7:0]        bad_cmd_count
);

  state_t            state_reg, state_next;
  logic              is_fill_reg, is_fill_next;
  logic [8:0]        remaining_reg, remaining_next;
  logic              wr_valid_reg, wr_valid_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [7:0]        wr_data_reg, wr_data_next;
  logic [7:0]        bad_count_reg, bad_count_next;
  logic              overrun_reg, overrun_next;

  logic       fifo_pop;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_drop;

  ser_byte_fifo #(
    .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_full),
    .din   (rx_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .drop  (fifo_drop)
  );

  // Every state except WRITE consumes one byte per cycle when one is available.
  assign fifo_pop = (state_reg != ST_WRITE) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      is_fill_reg   <= 1'b0;
      remaining_reg <= '0;
      wr_valid_reg  <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      bad_count_reg <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      is_fill_reg   <= is_fill_next;
      remaining_reg <= remaining_next;
      wr_valid_reg  <= wr_valid_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      bad_count_reg <= bad_count_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    is_fill_next   = is_fill_reg;
    remaining_next = remaining_reg;
    wr_valid_next  = wr_valid_reg;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    bad_count_next = bad_count_reg;
    overrun_next   = overrun_reg | fifo_drop;

    case (state_reg)
      ST_IDLE: begin
        if (fifo_pop) begin
          if ((fifo_dout == OP_WRITE) || (fifo_dout == OP_FILL)) begin
            is_fill_next = (fifo_dout == OP_FILL);
            state_next   = ST_ADDR_HI;
          end else if (bad_count_reg != 8'hFF) begin
            bad_count_next = bad_count_reg + 1'b1;
          end
        end
      end
      ST_ADDR_HI: begin
        if (fifo_pop) begin
          wr_addr_next[15:8] = fifo_dout;
          state_next         = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (fifo_pop) begin
          wr_addr_next[7:0] = fifo_dout;
          state_next        = is_fill_reg ? ST_COUNT : ST_DATA;
        end
      end
      ST_COUNT: begin
        if (fifo_pop) begin
          remaining_next = {fifo_dout == 8'h00, fifo_dout};
          state_next     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (fifo_pop) begin
          wr_data_next = fifo_dout;
          state_next   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // First WRITE cycle launches the request from the freshly loaded data.
        if (!wr_valid_reg) begin
          wr_valid_next = 1'b1;
        end else if (wr_ready) begin
          remaining_next = remaining_reg - 1'b1;
          if (!is_fill_reg || (remaining_reg == 9'd1)) begin
            wr_valid_next = 1'b0;
            state_next    = ST_IDLE;
          end else begin
            wr_addr_next = wr_addr_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next    = ST_IDLE;
        wr_valid_next = 1'b0;
      end
    endcase
  end

  assign wr_valid      = wr_valid_reg;
  assign wr_addr       = wr_addr_reg;
  assign wr_data       = wr_data_reg;
  assign overrun       = overrun_reg;
  assign bad_cmd_count = bad_count_reg;
  assign busy          = (state_reg != ST_IDLE) || !fifo_empty || fifo_full;

endmodule

// File: tb/tb_ser_cmd_decoder.sv
// Self-checking bench: directed and random byte streams are parsed by a
// queue-based command model and compared with the observed write handshakes.
module tb_ser_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_full;
  logic [7:0]  rx_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        overrun;
  logic [7:0]  bad_cmd_count;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  int  checks = 0;
  int  failures = 0;
  wr_t act_q[$];
  wr_t exp_q[$];
  int  exp_bad = 0;
  int  valid_cycles = 0;
  bit  prev_stall = 0;
  wr_t prev_req;
  bit  rnd_done;

  ser_cmd_decoder dut (
    .clk           (clk),
    .reset         (reset),
    .rx_full       (rx_full),
    .rx_data       (rx_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .overrun       (overrun),
    .bad_cmd_count (bad_cmd_count)
  );

  always #5 clk = ~clk;

  // Monitor: records handshakes and checks request stability while stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!wr_valid || wr_addr !== prev_req.addr || wr_data !== prev_req.data) begin
            failures++;
            $display("FAIL hold_stable got valid=%0b addr=%h data=%h want valid=1 addr=%h data=%h",
                     wr_valid, wr_addr, wr_data, prev_req.addr, prev_req.data);
          end
        end
        if (wr_valid) valid_cycles++;
        if (wr_valid && wr_ready) act_q.push_back(wr_t'({wr_addr, wr_data}));
        prev_stall = wr_valid && !wr_ready;
        prev_req   = wr_t'({wr_addr, wr_data});
      end
    end
  end

  // Reference model: applies the command grammar to a whole byte stream.
  task automatic model_bytes(input logic [7:0] b[$]);
    int i = 0;
    int n;
    logic [15:0] base;
    while (i < b.size()) begin
      if (b[i] == 8'h01) begin
        if (i + 3 >= b.size()) break;
        exp_q.push_back(wr_t'({b[i+1], b[i+2], b[i+3]}));
        i += 4;
      end else if (b[i] == 8'h02) begin
        if (i + 4 >= b.size()) break;
        base = {b[i+1], b[i+2]};
        n = (b[i+3] == 8'h00) ? 256 : int'(b[i+3]);
        for (int k = 0; k < n; k++) exp_q.push_back(wr_t'({base + k[15:0], b[i+4]}));
        i += 5;
      end else begin
        if (exp_bad < 255) exp_bad++;
        i++;
      end
    end
  endtask

  task automatic send_bytes(input logic [7:0] b[$], input int gap);
    for (int i = 0; i < b.size(); i++) begin
      rx_full = 1'b1;
      rx_data = b[i];
      @(posedge clk); #1;
      rx_full = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (!busy && !wr_valid) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 3) begin
      failures++;
      $display("FAIL %s_idle_timeout got busy=%0b after %0d cycles want busy=0", name, busy, n);
    end
  endtask

  task automatic compare_writes(input string name);
    int bad_idx = -1;
    checks++;
    if (act_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_write_count got=%0d want=%0d", name, act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      if (bad_idx < 0 && act_q[i] !== exp_q[i]) bad_idx = i;
    end
    checks++;
    if (bad_idx >= 0) begin
      failures++;
      $display("FAIL %s_write_%0d got addr=%h data=%h want addr=%h data=%h", name, bad_idx,
               act_q[bad_idx].addr, act_q[bad_idx].data, exp_q[bad_idx].addr, exp_q[bad_idx].data);
    end
    $display("%s: %0d writes observed, %0d expected", name, act_q.size(), exp_q.size());
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_full = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    exp_bad = 0;
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_full = 1'b0;
    rx_data = 8'h00;
    wr_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got=%0b want=0", wr_valid); end
    checks++; if (wr_addr !== 16'h0000) begin failures++; $display("FAIL reset_wr_addr got=%h want=0000", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr_data got=%h want=00", wr_data); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b want=0", overrun); end
    checks++; if (bad_cmd_count !== 8'h00) begin failures++; $display("FAIL reset_bad_cmd got=%0d want=0", bad_cmd_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
    reset = 1'b0;
    exp_bad = 0;
    $display("test_reset done");
  endtask

  task automatic test_single_write();
    logic [7:0] b[$];
    b = '{8'h01, 8'h12, 8'h34, 8'hAB};
    wr_ready = 1'b1;
    model_bytes(b);
    valid_cycles = 0;
    send_bytes(b, 0);
    wait_idle(100, "single");
    checks++;
    if (valid_cycles != 1) begin failures++; $display("FAIL single_valid_cycles got=%0d want=1", valid_cycles); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%0b want=0", busy); end
    compare_writes("single");
  endtask

  task automatic test_fill_stall();
    logic [7:0] b[$];
    int n = 0;
    b = '{8'h02, 8'h00, 8'h10, 8'h03, 8'h5A};
    wr_ready = 1'b0;
    model_bytes(b);
    send_bytes(b, 0);
    while (!wr_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (!wr_valid) begin failures++; $display("FAIL fill_stall_valid got=0 want=1"); end
    repeat (5) begin @(posedge clk); #1; end
    wr_ready = 1'b1;
    wait_idle(100, "fill_stall");
    compare_writes("fill_stall");
  endtask

  task automatic test_fill_wrap();
    logic [7:0] b[$];
    logic [15:0] last;
    b = '{8'h02, 8'hFF, 8'hFF, 8'h00, 8'h77};
    wr_ready = 1'b1;
    model_bytes(b);
    send_bytes(b, 0);
    wait_idle(1000, "fill_wrap");
    last = (act_q.size() > 0) ? act_q[act_q.size()-1].addr : 16'hxxxx;
    checks++;
    if (last !== 16'h00FE) begin failures++; $display("FAIL fill_wrap_last_addr got=%h want=00fe", last); end
    compare_writes("fill_wrap");
  endtask

  task automatic test_bad_opcode();
    logic [7:0] b[$];
    logic [7:0] v;
    b = '{8'h7E, 8'h01, 8'h00, 8'h01, 8'h55};
    wr_ready = 1'b1;
    model_bytes(b);
    send_bytes(b, 0);
    wait_idle(100, "bad_op");
    checks++;
    if (bad_cmd_count !== 8'(exp_bad)) begin failures++; $display("FAIL bad_op_count got=%0d want=%0d", bad_cmd_count, exp_bad); end
    compare_writes("bad_op");
    b.delete();
    for (int i = 0; i < 300; i++) begin
      v = 8'($urandom_range(3, 255));
      if (i % 7 == 0) v = 8'h00;
      b.push_back(v);
    end
    model_bytes(b);
    send_bytes(b, 0);
    wait_idle(200, "bad_sat");
    checks++;
    if (bad_cmd_count !== 8'(exp_bad)) begin failures++; $display("FAIL bad_sat_count got=%0d want=%0d", bad_cmd_count, exp_bad); end
    compare_writes("bad_sat");
  endtask

  task automatic test_latency();
    logic [7:0] b[$];
    b = '{8'h01, 8'h00, 8'h05};
    wr_ready = 1'b1;
    send_bytes(b, 2);
    repeat (4) begin @(posedge clk); #1; end
    rx_full = 1'b1;
    rx_data = 8'hC3;
    @(posedge clk); #1;
    rx_full = 1'b0;
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL latency_n got=%0b want=0", wr_valid); end
    @(posedge clk); #1;
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL latency_n1 got=%0b want=0", wr_valid); end
    @(posedge clk); #1;
    checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL latency_n2 got=%0b want=1", wr_valid); end
    b.push_back(8'hC3);
    model_bytes(b);
    wait_idle(100, "latency");
    compare_writes("latency");
  endtask

  task automatic test_overrun();
    logic [7:0] f[$];
    logic [7:0] p[$];
    logic [7:0] all[$];
    int n = 0;
    f = '{8'h02, 8'h00, 8'h30, 8'h02, 8'hEE};
    p = '{8'h01, 8'h00, 8'h20, 8'hA1, 8'h01, 8'h00, 8'h21, 8'hA2};
    wr_ready = 1'b0;
    send_bytes(f, 0);
    while (!wr_valid && n < 50) begin @(posedge clk); #1; n++; end
    send_bytes(p, 0);
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_at_8 got=%0b want=0", overrun); end
    rx_full = 1'b1;
    rx_data = 8'h01;
    @(posedge clk); #1;
    rx_full = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_at_9 got=%0b want=1", overrun); end
    wr_ready = 1'b1;
    wait_idle(200, "overrun");
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%0b want=1", overrun); end
    all = f;
    foreach (p[i]) all.push_back(p[i]);
    model_bytes(all);
    compare_writes("overrun");
    do_reset();
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] b[$];
    int n = 0;
    b = '{8'h02, 8'h04, 8'h00, 8'h0A, 8'h3C};
    wr_ready = 1'b1;
    model_bytes(b);
    send_bytes(b, 0);
    while (act_q.size() < 3 && n < 100) begin @(posedge clk); #1; n++; end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0b want=0", wr_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b want=0", busy); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL midrst_overrun got=%0b want=0", overrun); end
    reset = 1'b0;
    exp_bad = 0;
    repeat (20) begin @(posedge clk); #1; end
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    compare_writes("midrst");
    b = '{8'h01, 8'h00, 8'h00, 8'h11};
    model_bytes(b);
    send_bytes(b, 0);
    wait_idle(100, "after_rst");
    compare_writes("after_rst");
  endtask

  task automatic test_random(input int round);
    logic [7:0] b[$];
    int kind;
    for (int c = 0; c < 16; c++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        b.push_back(8'h01);
        repeat (3) b.push_back(8'($urandom));
      end else if (kind == 1) begin
        b.push_back(8'h02);
        repeat (2) b.push_back(8'($urandom));
        b.push_back(8'($urandom_range(1, 4)));
        b.push_back(8'($urandom));
      end else begin
        b.push_back(8'($urandom_range(3, 255)));
      end
    end
    model_bytes(b);
    rnd_done = 0;
    fork
      begin
        send_bytes(b, 8);
        wait_idle(2000, "random");
        rnd_done = 1;
      end
      begin
        int stall = 0;
        while (!rnd_done) begin
          wr_ready = (stall >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
          stall = wr_ready ? 0 : stall + 1;
          @(posedge clk); #1;
        end
      end
    join
    wr_ready = 1'b1;
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL random_overrun got=%0b want=0", overrun); end
    checks++;
    if (bad_cmd_count !== 8'(exp_bad)) begin failures++; $display("FAIL random_bad_count got=%0d want=%0d", bad_cmd_count, exp_bad); end
    $display("random round %0d: %0d bytes", round, b.size());
    compare_writes("random");
  endtask

  initial begin
    reset = 1'b1;
    rx_full = 1'b0;
    rx_data = 8'h00;
    wr_ready = 1'b1;
    test_reset();
    test_single_write();
    test_fill_stall();
    test_fill_wrap();
    test_bad_opcode();
    do_reset();
    test_latency();
    test_overrun();
    test_reset_mid_burst();
    for (int r = 0; r < 3; r++) test_random(r);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ser_cmd_decoder.md
Name: ser_cmd_decoder

Overview:
- Consumes bytes from the serial receiver: a one-cycle "full" strobe plus an 8-bit byte.
- Buffers the bytes in a small FIFO and parses them into GPU framebuffer write commands.
- Issues single writes or address-incrementing fill bursts on a valid/ready write port toward the GPU memory arbiter.
- Decouples the slow serial byte stream from downstream stalls and reports overrun and protocol errors.

Parameters:
FIFO_DEPTH_LOG2, 3, log2 of byte FIFO depth (default 8 entries)
OP_WRITE, 8'h01, opcode for a single write: addr_hi, addr_lo, data
OP_FILL, 8'h02, opcode for a fill: addr_hi, addr_lo, count, data

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
rx_full  input  1  one-cycle strobe: rx_data holds a new byte
rx_data  input  8  received byte, valid when rx_full=1
wr_valid  output  1  write request valid
wr_ready  input  1  downstream accepts the write this cycle
wr_addr  output  16  write address
wr_data  output  8  write data
busy  output  1  FSM not in IDLE, or FIFO not empty
overrun  output  1  sticky: a byte was dropped because the FIFO was full
bad_cmd_count  output  8  saturating count of unknown opcodes

Behaviour:
- Reset (clk, synchronous, active-high): FIFO emptied; FSM to IDLE; wr_valid=0, wr_addr=0, wr_data=0, overrun=0, bad_cmd_count=0, busy=0. Reset mid-command or mid-burst abandons it with no further writes; the byte in flight on the same edge is discarded.
- FIFO push:
  - rx_full=1 pushes rx_data.
  - If the FIFO is full and there is no pop in the same cycle, the byte is dropped and overrun is set (sticky until reset).
  - Push and pop in the same cycle at full are legal: the byte is accepted and the count is unchanged.
  - Push and pop in the same cycle at empty are not possible, because pop requires the FIFO to be non-empty.
- FIFO output is registered. A byte pushed at edge N is poppable from edge N+1 onward.
- Pop: one byte per cycle, only while the FSM is in a byte-consuming state (IDLE, ADDR_HI, ADDR_LO, COUNT, DATA) and the FIFO is non-empty.
- FSM states:
  - IDLE: pop an opcode.
    - OP_WRITE or OP_FILL -> ADDR_HI; the opcode is latched.
    - Any other value -> stay in IDLE; bad_cmd_count+1, saturating at 255.
  - ADDR_HI: pop, load wr_addr[15:8] -> ADDR_LO.
  - ADDR_LO: pop, load wr_addr[7:0] -> COUNT if the opcode is FILL, else DATA.
  - COUNT: pop into an internal 9-bit remaining counter. Count 0 means 256 writes -> DATA.
  - DATA: pop, load wr_data; assert wr_valid -> WRITE.
  - WRITE: hold wr_valid, wr_addr and wr_data stable until wr_ready=1. At the handshake edge:
    - WRITE opcode: wr_valid=0 -> IDLE.
    - FILL opcode: remaining-1. If the result is 0 -> wr_valid=0, IDLE. Otherwise wr_addr+1 (wraps 16'hFFFF -> 16'h0000) and wr_valid stays 1, giving back-to-back writes at one per cycle while wr_ready=1.
- No bytes are popped in WRITE. The FIFO absorbs serial input during bursts; overrun occurs only if the stall outlasts FIFO_DEPTH byte times.
- Latency: with the FIFO empty and the FSM in DATA, a data byte strobed at edge N is popped at edge N+1, and wr_valid=1 after edge N+2.
- wr_valid never deasserts without a handshake, except on reset.
- busy is combinational from the state and FIFO count.
- Widths:
  - Address increment is modulo 2^16.
  - The remaining counter is 9 bits, loaded as {count==0, count}.
  - bad_cmd_count is 8-bit saturating.

Decomposition:
- Shared package ser_pkg:
  - opcode constants OP_WRITE and OP_FILL;
  - FSM state encoding (IDLE, ADDR_HI, ADDR_LO, COUNT, DATA, WRITE), 3-bit;
  - address width constant 16.
- Sub-module ser_byte_fifo: parameterised synchronous FIFO, 8-bit wide, 2^FIFO_DEPTH_LOG2 deep.
  - Ports: push, din, pop, dout, empty, full, plus a drop output used for overrun.
  - Registered output.
  - Full and empty derived from a (FIFO_DEPTH_LOG2+1)-bit count.
- The FSM and output registers live in ser_cmd_decoder.

Test Plan:
- Single write, wr_ready tied 1. Strobe 01 12 34 AB -> exactly one write addr=16'h1234 data=8'hAB; wr_valid high 1 cycle; busy=0 afterwards.
- Fill with stall. Strobe 02 00 10 03 5A; wr_ready=0 for 5 cycles, then 1 -> wr_valid stable during the stall, then writes to 0010, 0011, 0012 with data 5A; no fourth write.
- Fill wrap and count 0. Strobe 02 FF FF 00 77 -> 256 writes at addresses FFFF, 0000 .. 00FE; the last is 00FE; counter ends in IDLE.
- Bad opcode then valid command. Strobe 7E 01 00 01 55 -> bad_cmd_count=1; one write addr=0001 data=55. Also 300 bad opcodes -> bad_cmd_count saturates at 255.
- Overrun. wr_ready=0 during a FILL burst; strobe 9 bytes back-to-back -> 8 bytes retained, overrun=1, and the first 8 bytes are later processed in order.
- Reset mid-burst. Assert reset during FILL count=10 after 3 writes -> wr_valid=0 next cycle, FIFO empty, overrun=0, no further writes. A following 01 00 00 11 executes normally.
